// File: rtl/hub_slot.sv
// Round-robin hub sequencer: one access per cog per eight bus-enable edges.
// Latency: ack/read data one ena_bus edge after grant. No backpressure: cogs hold cog_req until ack.
module hub_slot #(
  parameter int COGS = 8,
  parameter int AW   = 14
) (
  input  logic                 clk_cog,
  input  logic                 res,
  input  logic                 ena_bus,
  input  logic [COGS-1:0]      cog_req,
  input  logic [COGS-1:0]      cog_w,
  input  logic [COGS*4-1:0]    cog_wb,
  input  logic [COGS*AW-1:0]   cog_a,
  input  logic [COGS*32-1:0]   cog_d,
  output logic                 mem_w,
  output logic [3:0]           mem_wb,
  output logic [AW-1:0]        mem_a,
  output logic [31:0]          mem_d,
  input  logic [31:0]          mem_q,
  output logic [COGS-1:0]      cog_ack,
  output logic [31:0]          cog_q,
  output logic [2:0]           slot
);

  logic          grant;
  logic [AW-1:0] sel_a;
  logic [31:0]   sel_d;
  logic [3:0]    sel_wb;
  logic          pend_vld;
  logic [2:0]    pend_id;

  always_comb begin
    sel_a  = cog_a[slot*AW +: AW];
    sel_d  = cog_d[slot*32 +: 32];
    sel_wb = cog_wb[slot*4 +: 4];
    grant  = cog_req[slot] & ~res;
  end

  // Top address bit selects the ROM half; writes there become reads.
  always_comb begin
    mem_a  = grant ? sel_a  : '0;
    mem_d  = grant ? sel_d  : '0;
    mem_wb = grant ? sel_wb : '0;
    mem_w  = grant & ena_bus & cog_w[slot] & ~sel_a[AW-1];
  end

  always_ff @(posedge clk_cog) begin
    if (res) begin
      slot     <= '0;
      pend_vld <= 1'b0;
      pend_id  <= '0;
      cog_ack  <= '0;
      cog_q    <= '0;
    end else if (ena_bus) begin
      slot     <= slot + 3'd1;
      pend_vld <= grant;
      pend_id  <= slot;
      if (pend_vld) begin
        cog_q   <= mem_q;
        cog_ack <= COGS'(1) << pend_id;
      end else begin
        cog_ack <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hub_slot.sv
// Randomized bench for hub_slot: behavioural hub memory, reference memory and per-cog request drivers.
module tb_hub_slot;
  logic         clk_cog = 1'b0;
  logic         res, ena_bus;
  logic [7:0]   cog_req, cog_w;
  logic [31:0]  cog_wb;
  logic [111:0] cog_a;
  logic [255:0] cog_d;
  logic         mem_w;
  logic [3:0]   mem_wb;
  logic [13:0]  mem_a;
  logic [31:0]  mem_d, mem_q;
  logic [7:0]   cog_ack;
  logic [31:0]  cog_q;
  logic [2:0]   slot;

  always #5 clk_cog = ~clk_cog;

  hub_slot dut (
    .clk_cog(clk_cog), .res(res), .ena_bus(ena_bus),
    .cog_req(cog_req), .cog_w(cog_w), .cog_wb(cog_wb), .cog_a(cog_a), .cog_d(cog_d),
    .mem_w(mem_w), .mem_wb(mem_wb), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q),
    .cog_ack(cog_ack), .cog_q(cog_q), .slot(slot)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] wb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (wb[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Hub memory: registered read of the pre-write contents, unguarded writes.
  logic [31:0] hub_mem [0:16383];
  always @(posedge clk_cog) begin
    if (ena_bus) begin
      mem_q <= hub_mem[mem_a];
      if (mem_w) hub_mem[mem_a] <= merge(hub_mem[mem_a], mem_d, mem_wb);
    end
  end

  int n_chk = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: expected bus state and what memory should hold.
  logic [31:0] ref_mem [0:16383];
  int          m_slot = 0, m_pid = 0;
  bit          m_pv = 0;
  logic [31:0] m_pdat = 0, m_q = 0;
  logic [7:0]  m_ack = 0;

  // Cog drivers
  bit          busy [8];
  bit          rq_w [8];
  logic [13:0] rq_a [8];
  logic [31:0] rq_d [8];
  logic [3:0]  rq_wb [8];
  int          done_cnt [8], grant_cyc [8], done_cyc [8], ack_run [8], last_len [8];
  logic [31:0] last_q [8];
  logic [7:0]  prev_ack = 0;
  bit          rand_en = 0, saw_w = 0;
  int          ena_mode = 0;
  int          order_q[$], order_t[$];

  task automatic start_req(input int k, input bit w, input logic [13:0] a, input logic [31:0] d, input logic [3:0] wb);
    busy[k] = 1; rq_w[k] = w; rq_a[k] = a; rq_d[k] = d; rq_wb[k] = wb;
  endtask

  function automatic logic [13:0] rand_addr();
    case ($urandom_range(0, 2))
      0:       return 14'h0010 + 14'($urandom_range(0, 7));
      1:       return 14'h2000 + 14'($urandom_range(0, 3));
      default: return 14'h0100 + 14'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic model_edge();
    logic [13:0] a;
    if (res) begin
      m_slot = 0; m_pv = 0; m_ack = 0; m_q = 0;
    end else if (ena_bus) begin
      if (m_pv) begin m_ack = 8'b1 << m_pid; m_q = m_pdat; end
      else m_ack = 0;
      m_pv = cog_req[m_slot];
      if (m_pv) begin
        a = cog_a[m_slot*14 +: 14];
        m_pid = m_slot;
        m_pdat = ref_mem[a];
        grant_cyc[m_slot] = cyc;
        if (cog_w[m_slot] && !a[13])
          ref_mem[a] = merge(ref_mem[a], cog_d[m_slot*32 +: 32], cog_wb[m_slot*4 +: 4]);
      end
      m_slot = (m_slot + 1) % 8;
    end
  endtask

  task automatic step(input bit rst);
    bit          g;
    logic [13:0] ea;
    @(negedge clk_cog);
    cyc++;
    chk("slot", slot, m_slot);
    chk("cog_ack", cog_ack, m_ack);
    chk("cog_q", cog_q, m_q);
    for (int k = 0; k < 8; k++) begin
      if (cog_ack[k] && !prev_ack[k] && busy[k]) begin
        busy[k] = 0; last_q[k] = cog_q; done_cnt[k]++; done_cyc[k] = cyc;
        order_q.push_back(k); order_t.push_back(cyc);
      end
      if (cog_ack[k]) ack_run[k]++;
      else if (ack_run[k] != 0) begin last_len[k] = ack_run[k]; ack_run[k] = 0; end
      if (rand_en && !busy[k] && !cog_ack[k] && $urandom_range(0, 3) == 0)
        start_req(k, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom));
    end
    prev_ack = cog_ack;
    for (int k = 0; k < 8; k++) begin
      cog_req[k] = busy[k];
      if (busy[k]) begin
        cog_w[k] = rq_w[k]; cog_a[k*14 +: 14] = rq_a[k];
        cog_d[k*32 +: 32] = rq_d[k]; cog_wb[k*4 +: 4] = rq_wb[k];
      end else begin
        cog_w[k] = 1'($urandom_range(0, 1)); cog_a[k*14 +: 14] = 14'($urandom);
        cog_d[k*32 +: 32] = $urandom; cog_wb[k*4 +: 4] = 4'($urandom);
      end
    end
    case (ena_mode)
      0:       ena_bus = 1'b1;
      1:       ena_bus = (cyc % 2 == 0);
      default: ena_bus = ($urandom_range(0, 2) != 0);
    endcase
    res = rst;
    #1;
    g  = cog_req[m_slot] && !res;
    ea = cog_a[m_slot*14 +: 14];
    chk("mem_a", mem_a, g ? ea : 14'h0);
    chk("mem_d", mem_d, g ? cog_d[m_slot*32 +: 32] : 32'h0);
    chk("mem_wb", mem_wb, g ? cog_wb[m_slot*4 +: 4] : 4'h0);
    chk("mem_w", mem_w, g && ena_bus && cog_w[m_slot] && !ea[13]);
    if (mem_w) saw_w = 1;
    model_edge();
  endtask

  task automatic access(input int k, input bit w, input logic [13:0] a, input logic [31:0] d,
                        input logic [3:0] wb, output logic [31:0] q);
    int n0, t;
    n0 = done_cnt[k];
    t = 0;
    start_req(k, w, a, d, wb);
    while (done_cnt[k] == n0 && t < 64) begin step(0); t++; end
    chk("access_done", done_cnt[k] - n0, 1);
    busy[k] = 0;
    q = last_q[k];
  endtask

  logic [31:0] q;
  int          t;

  initial begin
    for (int i = 0; i < 16384; i++) begin hub_mem[i] = init_word(i); ref_mem[i] = init_word(i); end
    for (int k = 0; k < 8; k++) begin
      busy[k] = 0; done_cnt[k] = 0; ack_run[k] = 0; last_len[k] = 0; last_q[k] = 0;
      grant_cyc[k] = 0; done_cyc[k] = 0;
    end
    mem_q = 0; res = 1; ena_bus = 1; cog_req = 0; cog_w = 0; cog_wb = 0; cog_a = 0; cog_d = 0;

    step(1); step(1);
    step(0);
    chk("rst_slot", slot, 0);
    chk("rst_ack", cog_ack, 0);
    saw_w = 0;
    for (int i = 0; i < 9; i++) step(0);
    chk("idle_no_write", saw_w, 0);

    saw_w = 0;
    access(3, 1, 14'h0010, 32'hDEADBEEF, 4'hF, q);
    chk("c3_write_seen", saw_w, 1);
    // ack is observed at the negedge after the edge that registers it
    chk("c3_latency", done_cyc[3] - grant_cyc[3], 2);
    access(3, 0, 14'h0010, 32'h0, 4'h0, q);
    chk("c3_readback", q, 32'hDEADBEEF);

    saw_w = 0;
    access(5, 1, 14'h2000, 32'h12345678, 4'hF, q);
    chk("c5_rom_no_write", saw_w, 0);
    access(5, 0, 14'h2000, 32'h0, 4'h0, q);
    chk("c5_rom_readback", q, init_word(14'h2000));

    order_q.delete(); order_t.delete();
    for (int k = 0; k < 8; k++) start_req(k, 0, 14'h0100 + 14'(k), 32'h0, 4'h0);
    t = 0;
    while (order_q.size() < 8 && t < 40) begin step(0); t++; end
    chk("all8_count", order_q.size(), 8);
    for (int i = 1; i < order_q.size(); i++) begin
      chk("all8_order", order_q[i], (order_q[0] + i) % 8);
      chk("all8_gap", order_t[i] - order_t[i-1], 1);
    end
    for (int k = 0; k < 8; k++) chk("all8_q", last_q[k], init_word(32'h100 + k));
    for (int k = 0; k < 8; k++) busy[k] = 0;

    ena_mode = 1;
    access(6, 1, 14'h0020, 32'hCAFEF00D, 4'b0101, q);
    access(6, 0, 14'h0020, 32'h0, 4'h0, q);
    chk("tog_readback", q, merge(init_word(14'h0020), 32'hCAFEF00D, 4'b0101));
    for (int i = 0; i < 4; i++) step(0);
    chk("tog_ack_len", last_len[6], 2);
    ena_mode = 0;

    start_req(2, 0, 14'h0102, 32'h0, 4'h0);
    t = 0;
    while (!(m_pv && m_pid == 2) && t < 20) begin step(0); t++; end
    chk("rst_grant_seen", m_pv && m_pid == 2, 1);
    step(1);
    step(0);
    chk("rst_no_ack2", cog_ack[2], 0);
    chk("rst_slot0", slot, 0);
    chk("rst_q0", cog_q, 0);
    t = 0;
    while (busy[2] && t < 20) begin step(0); t++; end
    chk("post_rst_done", busy[2], 0);
    chk("post_rst_q", last_q[2], init_word(14'h0102));

    rand_en = 1; ena_mode = 2;
    for (int i = 0; i < 3000; i++) step($urandom_range(0, 79) == 0);
    rand_en = 0; ena_mode = 0;
    for (int i = 0; i < 24; i++) step(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hub_slot.md
# hub_slot

Round-robin hub access sequencer that sits directly upstream of the hub memory. It grants each of the eight cogs one hub memory access per eight bus-enable cycles. In the granted cog's slot it drives the hub memory's write, byte-strobe, address and data inputs. It then captures the returned long and delivers it to that cog with a one-hot acknowledge. Writes aimed at the ROM half of the address space ($8000–$FFFF) are suppressed here, because the hub memory does not guard its RAM array against them.

## Interface
- COGS, 8, number of requesters; fixed at 8, and the slot counter is 3 bits.
- AW, 14, long-address width, matching the hub memory address.
- clk_cog  in  1  system clock; all state updates on its rising edge.
- res  in  1  reset, synchronous, active-high.
- ena_bus  in  1  bus enable; the slot advances and state updates only on edges where it is high.
- cog_req  in  8  per-cog request, held by the cog until its ack.
- cog_w  in  8  per-cog write flag.
- cog_wb  in  32  per-cog byte strobes; cog k uses [4k+3:4k].
- cog_a  in  112  per-cog long address; cog k uses [14k+13:14k].
- cog_d  in  256  per-cog write data; cog k uses [32k+31:32k].
- mem_w  out  1  write to hub memory.
- mem_wb  out  4  byte strobes to hub memory.
- mem_a  out  14  address to hub memory.
- mem_d  out  32  write data to hub memory.
- mem_q  in  32  hub memory read data, valid one ena_bus edge after the address is sampled.
- cog_ack  out  8  one-hot completion; bit k marks the end of cog k's access.
- cog_q  out  32  read data, shared by all cogs; only meaningful to the acked cog.
- slot  out  3  cog that owns the current bus cycle.

## Operation
- slot register: on each ena_bus edge, slot <= slot+1, wrapping 7 -> 0. It holds when ena_bus is low.
- Grant is combinational: g = cog_req[slot] & !res.
- Memory drive:
  - mem_a = g ? cog_a[slot] : 0.
  - mem_d = g ? cog_d[slot] : 0.
  - mem_wb = g ? cog_wb[slot] : 0.
  - mem_w = g & ena_bus & cog_w[slot] & !cog_a[slot][13].
- ROM-region writes (a[13]=1) are forced to read-only: mem_w=0, and the access still completes and acks. mem_wb is still driven; the hub memory ignores it without mem_w.
- Pipeline register pend (valid bit + 3-bit cog id): on an ena_bus edge, pend <= {g, slot}.
- Completion: on an ena_bus edge where pend.valid=1:
  - cog_q <= mem_q;
  - cog_ack <= 1 << pend.id.
  - On every other ena_bus edge, cog_ack <= 0. cog_q holds its value.
- Writes return the pre-write contents in cog_q, because the hub memory reads before it writes. This is defined behaviour.
- A cog that drops cog_req before its slot generates no access and no ack.
- A cog that keeps cog_req high after its ack is granted again in its next slot. It is the cog's job to drop req on ack.
- Request fields are sampled only on the grant edge; they may change afterwards without effect.
- Reset, applied on any edge, regardless of ena_bus:
  - slot=0, pend.valid=0, cog_ack=0, cog_q=0.
  - An access that is in flight is dropped and never acked.
  - A grant edge with res high issues no write.

## Timing
- E0: ena_bus edge with slot=k and cog_req[k]=1. The hub memory samples the address/data; a write lands here.
- E1: the next ena_bus edge. cog_q and cog_ack[k] are registered.
- cog_ack[k] is high from E1 until E2 (the following ena_bus edge), so exactly one bus period regardless of the ena_bus duty cycle.
- Request-to-grant wait: 0 to 7 bus periods. Grant-to-ack: 1 bus period. Worst case from request to ack: 8 bus periods.
- At most one cog_ack bit is high at a time. Acks for consecutive slots appear on consecutive bus periods.
- No combinational path from cog inputs to cog_ack or cog_q. The paths from cog inputs to mem_* are combinational through the slot mux.

## Test plan
- Reset, then ena_bus held high: slot counts 0..7,0. All cog_ack=0, mem_w=0, mem_a=0.
- Cog 3 writes a=$0010, d=$DEADBEEF, wb=4'b1111 when slot=3:
  - mem_w=1 during that cycle;
  - ack[3] appears 1 bus period later;
  - a later cog 3 read of $0010 returns $DEADBEEF.
- Cog 5 writes a=$2000 (ROM region): mem_w=0, ack[5] still asserted, and a later read of $2000 returns the ROM word unchanged.
- All 8 cogs request reads simultaneously: acks arrive one-hot on consecutive bus periods in slot order, each with the correct cog_q.
- ena_bus toggles every 2nd clock: slot, pend and ack update only on enabled edges; ack stays high for 2 clocks.
- res asserted on the edge after cog 2's grant: no ack[2], slot=0, cog_q=0; the next access after reset completes normally.
